// File: rtl/tdm_demux_1to8.sv
// tdm_demux_1to8 -- receive end of the 8-way time-division link.
// Steps a slot counter (Selector), steers each accepted sample into a shadow
// lane and publishes the completed frame on Out with a one-cycle out_valid
// strobe. Early frame_sync and mid-frame stalls abort the frame with a
// one-cycle frame_err strobe; the aborted lanes never reach Out.
//
// Optional build macro: TDM_PARITY_CHECK_EN
//   defined   -> each frame carries a ninth even-parity slot (index 8),
//                Selector is 4 bits wide, and a parity mismatch aborts the
//                frame with frame_err instead of publishing it.
//   undefined -> plain 8-slot frames, 3-bit Selector, no parity logic.
module tdm_demux_1to8 #(
    parameter int DATA_W  = 1,
    parameter int TIMEOUT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_W-1:0]     In,
    input  logic                  in_valid,
    input  logic                  frame_sync,
    output logic [8*DATA_W-1:0]   Out,
    output logic                  out_valid,
    output logic                  frame_err,
`ifdef TDM_PARITY_CHECK_EN
    output logic [3:0]            Selector
`else
    output logic [2:0]            Selector
`endif
);

`ifdef TDM_PARITY_CHECK_EN
    // Nine slots per frame; all eight data lanes are held in shadow until the
    // parity slot arrives.
    localparam int SEL_W        = 4;
    localparam int NSLOT        = 9;
    localparam int SHADOW_LANES = 8;
`else
    // Eight slots per frame; lane 7 goes straight from In to Out on completion,
    // so only lanes 0..6 need shadow storage.
    localparam int SEL_W        = 3;
    localparam int NSLOT        = 8;
    localparam int SHADOW_LANES = 7;
`endif

    localparam int SHADOW_W = SHADOW_LANES * DATA_W;

    localparam logic [0:0] S_IDLE    = 1'b0;
    localparam logic [0:0] S_COLLECT = 1'b1;

    localparam logic [SEL_W-1:0] SEL_ZERO = {SEL_W{1'b0}};
    localparam logic [SEL_W-1:0] SEL_ONE  = SEL_W'(1);
    localparam logic [SEL_W-1:0] SEL_LAST = SEL_W'(NSLOT - 1);

    localparam logic [7:0] IDLE_ZERO = 8'd0;
    localparam logic [7:0] IDLE_ONE  = 8'd1;
    localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);

`ifdef TDM_PARITY_CHECK_EN
    // Even parity across the eight data lanes: bitwise XOR of all lanes.
    function automatic logic [DATA_W-1:0] frame_parity(input logic [8*DATA_W-1:0] lanes);
        logic [DATA_W-1:0] acc;
        acc = {DATA_W{1'b0}};
        for (int k = 0; k < 8; k++) begin
            acc = acc ^ lanes[k*DATA_W +: DATA_W];
        end
        return acc;
    endfunction
`endif

    logic [0:0]          state_r,  state_s;
    logic [SEL_W-1:0]    sel_r,    sel_s;
    logic [7:0]          idle_r,   idle_s;
    logic [7:0]          idle_inc_s;
    logic [SHADOW_W-1:0] shadow_r, shadow_s;
    logic [8*DATA_W-1:0] out_r,    out_s;
    logic                out_valid_r, out_valid_s;
    logic                frame_err_r, frame_err_s;

    assign idle_inc_s = idle_r + IDLE_ONE;

    // Next-state logic: slot steering, frame completion and abort detection.
    always_comb begin
        state_s     = state_r;
        sel_s       = sel_r;
        idle_s      = idle_r;
        shadow_s    = shadow_r;
        out_s       = out_r;
        out_valid_s = 1'b0;
        frame_err_s = 1'b0;

        case (state_r)
            S_IDLE: begin
                sel_s  = SEL_ZERO;
                idle_s = IDLE_ZERO;
                if (in_valid && frame_sync) begin
                    shadow_s                = {SHADOW_W{1'b0}};
                    shadow_s[0 +: DATA_W]   = In;
                    sel_s                   = SEL_ONE;
                    state_s                 = S_COLLECT;
                end else begin
                    // Unsynchronised samples are dropped without complaint.
                    state_s = S_IDLE;
                end
            end

            S_COLLECT: begin
                if (in_valid && frame_sync) begin
                    // Early sync: abort the partial frame, restart on this sample.
                    frame_err_s           = 1'b1;
                    shadow_s              = {SHADOW_W{1'b0}};
                    shadow_s[0 +: DATA_W] = In;
                    sel_s                 = SEL_ONE;
                    idle_s                = IDLE_ZERO;
                    state_s               = S_COLLECT;
                end else if (in_valid) begin
                    idle_s = IDLE_ZERO;
                    if (sel_r == SEL_LAST) begin
`ifdef TDM_PARITY_CHECK_EN
                        if (frame_parity(shadow_r) == In) begin
                            out_s       = shadow_r;
                            out_valid_s = 1'b1;
                        end else begin
                            frame_err_s = 1'b1;
                        end
`else
                        out_s       = {In, shadow_r};
                        out_valid_s = 1'b1;
`endif
                        sel_s   = SEL_ZERO;
                        state_s = S_IDLE;
                    end else begin
                        shadow_s[DATA_W*int'(sel_r) +: DATA_W] = In;
                        sel_s = sel_r + SEL_ONE;
                    end
                end else begin
                    // Stall: abort once the idle run reaches the tolerated limit.
                    if (idle_inc_s == TIMEOUT_C) begin
                        frame_err_s = 1'b1;
                        shadow_s    = {SHADOW_W{1'b0}};
                        sel_s       = SEL_ZERO;
                        idle_s      = IDLE_ZERO;
                        state_s     = S_IDLE;
                    end else begin
                        idle_s = idle_inc_s;
                    end
                end
            end

            default: begin
                state_s  = S_IDLE;
                sel_s    = SEL_ZERO;
                idle_s   = IDLE_ZERO;
                shadow_s = {SHADOW_W{1'b0}};
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= S_IDLE;
            sel_r       <= SEL_ZERO;
            idle_r      <= IDLE_ZERO;
            shadow_r    <= {SHADOW_W{1'b0}};
            out_r       <= {(8*DATA_W){1'b0}};
            out_valid_r <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            sel_r       <= sel_s;
            idle_r      <= idle_s;
            shadow_r    <= shadow_s;
            out_r       <= out_s;
            out_valid_r <= out_valid_s;
            frame_err_r <= frame_err_s;
        end
    end

    assign Out       = out_r;
    assign out_valid = out_valid_r;
    assign frame_err = frame_err_r;
    assign Selector  = sel_r;

endmodule

// File: tb/tb_tdm_demux_1to8.sv
// Directed self-checking bench for tdm_demux_1to8 (DATA_W=1, TIMEOUT=15).
// When TDM_PARITY_CHECK_EN is defined the bench appends the parity slot to
// every frame and adds the parity-mismatch case.
module tb_tdm_demux_1to8;

    logic       clk;
    logic       reset;
    logic [0:0] In;
    logic       in_valid;
    logic       frame_sync;
    logic [7:0] Out;
    logic       out_valid;
    logic       frame_err;
`ifdef TDM_PARITY_CHECK_EN
    logic [3:0] Selector;
`else
    logic [2:0] Selector;
`endif

    int checks   = 0;
    int failures = 0;

    tdm_demux_1to8 #(.DATA_W(1), .TIMEOUT(15)) dut (
        .clk        (clk),
        .reset      (reset),
        .In         (In),
        .in_valid   (in_valid),
        .frame_sync (frame_sync),
        .Out        (Out),
        .out_valid  (out_valid),
        .frame_err  (frame_err),
        .Selector   (Selector)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic d);
        in_valid   = v;
        frame_sync = s;
        In         = d;
        tick();
    endtask

    // Full frame: slot k carries lanes[k]; optional parity slot, optionally corrupted.
    task automatic send_frame(input logic [7:0] lanes, input logic par_flip);
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, (k == 0), lanes[k]);
        end
`ifdef TDM_PARITY_CHECK_EN
        drive(1'b1, 1'b0, (^lanes) ^ par_flip);
`else
        if (par_flip) begin
            $display("note: parity flip ignored in 8-slot build");
        end
`endif
    endtask

    initial begin
        reset = 1'b1; In = 1'b0; in_valid = 1'b0; frame_sync = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_eq("rst_out",   Out,       32'h00);
        check_eq("rst_ov",    out_valid, 32'h0);
        check_eq("rst_fe",    frame_err, 32'h0);
        check_eq("rst_sel",   Selector,  32'h0);

        // Single frame 1,0,1,1,0,0,1,0.
        send_frame(8'b0100_1101, 1'b0);
        check_eq("f1_ov",  out_valid, 32'h1);
        check_eq("f1_out", Out,       32'h4D);
        check_eq("f1_sel", Selector,  32'h0);
        check_eq("f1_fe",  frame_err, 32'h0);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("f1_ov_drop", out_valid, 32'h0);
        check_eq("f1_hold",    Out,       32'h4D);

        // Back-to-back frames, no dead cycle.
        send_frame(8'hFF, 1'b0);
        check_eq("b2b1_ov",  out_valid, 32'h1);
        check_eq("b2b1_out", Out,       32'hFF);
        drive(1'b1, 1'b1, 1'b0);
        check_eq("b2b2_ov_low", out_valid, 32'h0);
        check_eq("b2b2_sel",    Selector,  32'h1);
        for (int k = 1; k < 8; k++) drive(1'b1, 1'b0, 1'b0);
`ifdef TDM_PARITY_CHECK_EN
        drive(1'b1, 1'b0, 1'b0);
`endif
        check_eq("b2b2_ov",  out_valid, 32'h1);
        check_eq("b2b2_out", Out,       32'h00);
        drive(1'b0, 1'b0, 1'b0);

        // Early sync: partial frame of zeros discarded, new frame of ones.
        drive(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) drive(1'b1, 1'b0, 1'b0);
        check_eq("es_sel5", Selector, 32'h5);
        drive(1'b1, 1'b1, 1'b1);
        check_eq("es_fe",  frame_err, 32'h1);
        check_eq("es_ov0", out_valid, 32'h0);
        check_eq("es_sel", Selector,  32'h1);
        for (int k = 1; k < 8; k++) begin
            drive(1'b1, 1'b0, 1'b1);
            if (k == 1) check_eq("es_fe_drop", frame_err, 32'h0);
            if (k == 1) check_eq("es_out_hold", Out, 32'h00);
        end
`ifdef TDM_PARITY_CHECK_EN
        drive(1'b1, 1'b0, 1'b0);
`endif
        check_eq("es_ov",  out_valid, 32'h1);
        check_eq("es_out", Out,       32'hFF);
        drive(1'b0, 1'b0, 1'b0);

        // Stall of exactly TIMEOUT idle cycles aborts the frame.
        drive(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) drive(1'b0, 1'b0, 1'b0);
        check_eq("to_fe14", frame_err, 32'h0);
        check_eq("to_sel14", Selector, 32'h4);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("to_fe",  frame_err, 32'h1);
        check_eq("to_sel", Selector,  32'h0);
        check_eq("to_out", Out,       32'hFF);
        check_eq("to_ov",  out_valid, 32'h0);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("to_fe_drop", frame_err, 32'h0);

        // Stall of 14 cycles then resume: slots 1,0,1,0 | 1,1,0,0 -> 0x35.
        drive(1'b1, 1'b1, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++) drive(1'b0, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b1);
        check_eq("st14_fe",  frame_err, 32'h0);
        check_eq("st14_sel", Selector,  32'h5);
        drive(1'b1, 1'b0, 1'b1);
        drive(1'b1, 1'b0, 1'b0);
        drive(1'b1, 1'b0, 1'b0);
`ifdef TDM_PARITY_CHECK_EN
        drive(1'b1, 1'b0, 1'b0);
`endif
        check_eq("st14_ov",  out_valid, 32'h1);
        check_eq("st14_out", Out,       32'h35);
        drive(1'b0, 1'b0, 1'b0);

        // Reset mid-frame: silent discard.
        drive(1'b1, 1'b1, 1'b1);
        for (int k = 0; k < 5; k++) drive(1'b1, 1'b0, 1'b1);
        reset = 1'b1;
        drive(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        check_eq("mr_out", Out,       32'h00);
        check_eq("mr_sel", Selector,  32'h0);
        check_eq("mr_fe",  frame_err, 32'h0);
        drive(1'b0, 1'b0, 1'b0);
        check_eq("mr_fe2", frame_err, 32'h0);
        send_frame(8'hA6, 1'b0);
        check_eq("mr_ov",  out_valid, 32'h1);
        check_eq("mr_outf", Out,      32'hA6);
        drive(1'b0, 1'b0, 1'b0);

`ifdef TDM_PARITY_CHECK_EN
        // Parity: good frame publishes, corrupted parity aborts and holds Out.
        send_frame(8'h0F, 1'b0);
        check_eq("par_ok_ov",  out_valid, 32'h1);
        check_eq("par_ok_out", Out,       32'h0F);
        drive(1'b0, 1'b0, 1'b0);
        send_frame(8'hF0, 1'b1);
        check_eq("par_bad_fe",  frame_err, 32'h1);
        check_eq("par_bad_ov",  out_valid, 32'h0);
        check_eq("par_bad_out", Out,       32'h0F);
        check_eq("par_bad_sel", Selector,  32'h0);
        drive(1'b0, 1'b0, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1to8.md
Name: tdm_demux_1to8

Overview:
- Receive end of the 8-way time-division link.
- The transmit side serialises eight slots through the 8-to-1 mux tree by stepping Selector 0..7.
- This block does the inverse. It steps its own slot counter, steers each incoming sample into register lane 0..7, and publishes the assembled frame as one parallel word with a single-cycle valid strobe.
- Detects malformed frames (early sync, stall timeout).

Parameters:
- DATA_W, 1, width of one slot sample.
- TIMEOUT, 15, max consecutive idle cycles (in_valid low) tolerated mid-frame before abort; legal range 1..255.

Ports:
- clk  input  1  clock, all logic on rising edge
- reset  input  1  synchronous, active-high reset
- In  input  DATA_W  slot sample
- in_valid  input  1  In carries a sample this cycle
- frame_sync  input  1  marks slot 0 of a frame; only meaningful with in_valid
- Out  output  8*DATA_W  assembled frame; lane k = Out[k*DATA_W +: DATA_W] = slot k
- out_valid  output  1  one-cycle strobe, Out just updated
- frame_err  output  1  one-cycle strobe, frame aborted
- Selector  output  3  slot index expected for the next accepted sample

Behaviour:
- Reset: all reset values take effect on the clock edge where reset=1.
  - Out=0, out_valid=0, frame_err=0, Selector=0, state=IDLE.
  - Shadow lanes and idle counter are cleared.
  - Reset mid-frame discards the partial frame silently; no frame_err.
- States: IDLE, COLLECT.
- IDLE:
  - Selector=0.
  - in_valid & frame_sync: write In to shadow lane 0, Selector<=1, go COLLECT.
  - in_valid without frame_sync: ignored, no error.
- COLLECT, sample accepted (in_valid & !frame_sync):
  - Write In to shadow lane Selector; Selector<=Selector+1; clear the idle counter.
- COLLECT, last slot (sample accepted with Selector==7):
  - Out <= shadow lanes 0..6 concatenated with the new sample as lane 7.
  - out_valid=1 for exactly that next cycle.
  - Selector wraps to 0; go IDLE.
  - Latency: out_valid is high in the cycle after slot 7 is accepted.
- Back-to-back frames: frame_sync in the cycle immediately after slot 7 is accepted as slot 0 of the new frame. Zero dead cycles between frames.
- COLLECT, early sync (in_valid & frame_sync):
  - frame_err=1 next cycle; the partial frame is discarded.
  - The sample is taken as slot 0 of a new frame: lane 0 written, Selector<=1, stay COLLECT.
- COLLECT, stall (in_valid low):
  - The idle counter increments each cycle.
  - When it reaches TIMEOUT: frame_err=1 next cycle, go IDLE, Selector=0, counter cleared.
  - A sample arriving on the same edge the counter would reach TIMEOUT is accepted; the counter clears and no error is raised.
- Out holds its value between frames; it changes only on completion.
- Shadow lanes of an aborted frame never appear on Out.
- out_valid and frame_err are never high in the same cycle.

Optional Feature:
- Macro: TDM_PARITY_CHECK_EN.
- Defined:
  - Each frame carries a ninth slot, index 8, holding even parity: bitwise XOR of lanes 0..7.
  - Selector widens to 4 bits; a frame completes on the sample accepted with Selector==8.
  - Parity match: normal out_valid path.
  - Mismatch: frame_err strobe instead of out_valid, Out unchanged, go IDLE.
- Undefined: 8-slot frames, Selector 3 bits, no parity logic.

Test Plan:
- Frame in one 8-cycle burst, DATA_W=1: reset, then in_valid=1 for 8 cycles, frame_sync on the first, In sequence 1,0,1,1,0,0,1,0 → out_valid one cycle after the 8th sample, Out=8'b01001101, Selector back to 0.
- Two frames back-to-back, 16 consecutive valid cycles: frame 1 slots all 1 → Out=8'hFF, out_valid strobe. Frame 2 slots all 0, sync on cycle 9 → second strobe exactly 8 cycles later, Out=8'h00.
- Early sync: sync, 4 samples, then sync again plus 7 more samples of value 1 → frame_err on the cycle after the second sync. out_valid after the 8th sample of the new frame, Out=8'hFF; prior partial frame never visible.
- Stall timeout, TIMEOUT=15: sync + 3 samples, then in_valid=0 for 15 cycles → frame_err one cycle after the 15th idle cycle, Selector=0, Out unchanged. Stall of 14 idle cycles then resume → no error, frame completes normally.
- Reset mid-frame: sync + 5 samples, reset for 1 cycle → Out=0, Selector=0, no frame_err. Subsequent clean frame completes normally.
- With TDM_PARITY_CHECK_EN: lanes 8'h0F with parity slot 0 → out_valid, Out=8'h0F. Same lanes with parity slot 1 → frame_err, Out keeps previous value.
